// File: rtl/rx_packet_fifo.sv
// Packet-committing RX byte FIFO: 1-cycle registered read, no backpressure (full drops bytes and discards the packet).
// Optional RX_PKT_FIFO_STATS_EN adds saturating good_cnt/bad_cnt packet counters.
module rx_packet_fifo #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rcving,
  input  logic              w_enable,
  input  logic              r_error,
  input  logic [7:0]        rcv_data,
  input  logic              flush,
  input  logic              r_enable,
  output logic [7:0]        rx_data,
  output logic [ADDR_W:0]   occupancy,
  output logic              empty,
  output logic              pkt_done,
  output logic              pkt_err
`ifdef RX_PKT_FIFO_STATS_EN
  ,
  output logic [7:0]        good_cnt,
  output logic [7:0]        bad_cnt
`endif
);

  localparam int PW = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT, DISCARD} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   wr_ptr, cmt_ptr, rd_ptr;
  logic            ovf;
  logic [7:0]      mem [DEPTH];
  logic            full, wr_ok, wr_drop, rd_ok;

  assign full      = (wr_ptr - rd_ptr) == PW'(DEPTH);
  assign wr_ok     = (state == ACTIVE) && w_enable && !full && !flush;
  assign wr_drop   = (state == ACTIVE) && w_enable && full;
  assign occupancy = cmt_ptr - rd_ptr;
  assign empty     = (cmt_ptr == rd_ptr);
  assign rd_ok     = r_enable && !empty && !flush;
  assign pkt_done  = (state == COMMIT);
  assign pkt_err   = (state == DISCARD);

  // A byte dropped in the final cycle of a packet still condemns that packet.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rcving) state_nxt = ACTIVE;
      ACTIVE:  if (!rcving) state_nxt = (r_error || ovf || wr_drop) ? DISCARD : COMMIT;
      COMMIT:  state_nxt = IDLE;
      DISCARD: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      rd_ptr  <= '0;
      ovf     <= 1'b0;
    end else if (flush) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      rd_ptr  <= '0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && rcving) ovf <= 1'b0;
      if (wr_drop)                 ovf <= 1'b1;
      if (wr_ok)                   wr_ptr <= wr_ptr + 1'b1;
      if (state == COMMIT)         cmt_ptr <= wr_ptr;
      if (state == DISCARD)        wr_ptr <= cmt_ptr;
      if (rd_ok)                   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[ADDR_W-1:0]] <= rcv_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     rx_data <= 8'h00;
    else if (rd_ok) rx_data <= mem[rd_ptr[ADDR_W-1:0]];
  end

`ifdef RX_PKT_FIFO_STATS_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      good_cnt <= 8'h00;
      bad_cnt  <= 8'h00;
    end else if (flush) begin
      good_cnt <= 8'h00;
      bad_cnt  <= 8'h00;
    end else begin
      if (state == COMMIT && good_cnt != 8'hFF)  good_cnt <= good_cnt + 8'h01;
      if (state == DISCARD && bad_cnt != 8'hFF)  bad_cnt  <= bad_cnt + 8'h01;
    end
  end
`endif

endmodule
